conv_frame_writer: RTL and testbench
====================================

# conv_frame_writer

Sink-side companion to the 3x3 edge-convolution window. Takes the window's free-running 12-bit RGB444 output stream, discards the pipeline-fill interval, and tracks the raster position of each window centre pixel. Buffers {address, pixel} pairs in a small FIFO and writes them to the frame buffer through a ready-gated write port. Reports frame completion and overflow.

## Interface
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in lines.
- LATENCY, 1285, cycles from the `frame_start` cycle to the first valid centre pixel on `pix_in`.
- FIFO_DEPTH, 8, write-buffer entries; power of 2, at least 2.
- ADDR_W, 19, frame-buffer address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- frame_start  in  1  one-cycle pulse; the window receives the first frame pixel in this cycle.
- pix_in  in  12  window output {R[3:0], G[3:0], B[3:0]}; no backpressure.
- mem_addr  out  ADDR_W  write address, taken from the FIFO head.
- mem_data  out  12  write data, taken from the FIFO head.
- mem_we  out  1  high whenever the FIFO is non-empty.
- mem_ready  in  1  write accepted when `mem_we && mem_ready`.
- busy  out  1  high in FILL, STREAM and DRAIN.
- frame_done  out  1  one-cycle pulse on completion.
- overflow  out  1  sticky; set when a push is dropped.

## Operation
- **FSM:** IDLE -> FILL -> STREAM -> DRAIN -> DONE -> IDLE.
- **IDLE:** on `frame_start`, load the fill counter with LATENCY-1 and go to FILL. Clear `overflow`. Reset col = 0, row = 1, addr = IMG_W.
- **FILL:** decrement the fill counter each cycle. At 0, go to STREAM. `pix_in` is ignored.
- **STREAM:** one centre pixel per cycle for (IMG_H-2)*IMG_W cycles.
  - Each cycle, push {addr, pixel} and increment addr.
  - col wraps from IMG_W-1 to 0; row increments on each wrap.
  - After the push at row = IMG_H-2, col = IMG_W-1, go to DRAIN.
- **Border columns:** at col 0 and col IMG_W-1 the window straddles two lines. Handling depends on the configuration macro (see Configuration).
- **DRAIN:** no pushes. When the FIFO is empty, go to DONE.
- **DONE:** assert `frame_done` for one cycle and return to IDLE.
- **Ignored events:** `frame_start` outside IDLE is ignored. `mem_ready` has no effect while `mem_we` = 0.
- **Push when full:** if the FIFO is full and no pop occurs in the same cycle, the push is dropped and `overflow` is set. addr, col and row still advance.
- **Push when full with a simultaneous pop:** both are performed; no overflow.
- **Address arithmetic:** addr is a counter, with no multiplier. It is truncated to ADDR_W bits; IMG_W*IMG_H must be no more than 2^ADDR_W.
- **Reset asserted mid-frame:** immediately return to IDLE. FIFO is emptied and all outputs go to their reset values. Writes in flight are abandoned.

## Timing
- **Reset values:** `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `frame_done`=0, `overflow`=0.
- **First valid pixel:** `frame_start` in cycle t puts the FSM in FILL at t+1. The first centre pixel is sampled from `pix_in` at t+LATENCY.
- **Push to write:** a push in cycle n makes `mem_we` high at n+1 when the FIFO was empty. There is no bypass path.
- **Write ordering:** FIFO head outputs are stable while `mem_we && !mem_ready`. Writes leave in push order.
- **Completion latency:**
  - The last push is at t+LATENCY+(IMG_H-2)*IMG_W-1.
  - DRAIN lasts at least 1 cycle.
  - `frame_done` occurs no earlier than the last push + 3.
- **busy:** falls in the same cycle that `frame_done` is high.

## Configuration
- **BORDER_ZERO_EN defined:** pixels pushed at col 0 and col IMG_W-1 carry data 12'h000.
- **BORDER_ZERO_EN undefined:** border pixels carry `pix_in` unmodified.
- Push count, addresses and timing are identical in both builds.

## Test plan
Bench parameters: IMG_W=8, IMG_H=4, LATENCY=19, FIFO_DEPTH=4, `mem_ready` held 1 unless noted.

- **Basic frame:** `frame_start` at cycle 10, `pix_in` = cycle count -> 16 writes, addresses 8..23 in order. First write has data 29 (0x01D) at addr 8, with `mem_we` first high at cycle 30. `frame_done` pulses once.
- **BORDER_ZERO_EN defined:** same stimulus -> addresses 8, 15, 16, 23 write 0x000; all others carry their sampled value. Undefined: all 16 carry their sampled value.
- **Stall:** `mem_ready`=0 for 6 cycles from the first push -> the first 4 entries are held and 2 pushes are dropped. `overflow`=1; 14 writes total. `frame_done` still pulses; `overflow` clears on the next `frame_start`.
- **Full-and-pop:** `mem_ready`=0 until the FIFO is full, then held 1 -> no overflow and all 16 writes occur.
- **Restart ignored:** `frame_start` pulsed during STREAM -> ignored; the write sequence is identical to the basic frame.
- **Reset mid-frame:** `reset`=0 during STREAM after 5 pushes -> all outputs at reset values immediately and the FIFO is empty. A new frame after release produces the basic-frame result.

Source files
------------

// File: rtl/conv_frame_writer.sv
// conv_frame_writer
//
// Sink for the 3x3 edge-convolution window. Skips the window's pipeline-fill
// interval after frame_start, then tags each window centre pixel with its
// frame-buffer address. The {address, pixel} pairs are queued in a small FIFO
// and written through a ready-gated port. Completion and dropped pushes are
// reported.
//
// Optional feature macro: BORDER_ZERO_EN
//   defined   - pixels at col 0 and col IMG_W-1 are written as 12'h000
//   undefined - border pixels carry i_pix_in unmodified
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset_n      asynchronous active-low reset, clears all state
//   i_frame_start  one-cycle pulse; window sees first frame pixel this cycle
//   i_pix_in       window output {R,G,B} 4 bits each, no backpressure
//   o_mem_addr     write address (FIFO head)
//   o_mem_data     write data (FIFO head)
//   o_mem_we       write request, high while FIFO non-empty
//   i_mem_ready    write accepted when o_mem_we && i_mem_ready
//   o_busy         high in FILL, STREAM and DRAIN
//   o_frame_done   one-cycle completion pulse
//   o_overflow     sticky; set when a push is dropped, cleared on frame start
//
// Parameter constraints: FIFO_DEPTH is a power of 2 and >= 2, LATENCY >= 1,
// IMG_H >= 3, IMG_W*IMG_H <= 2**ADDR_W.
module conv_frame_writer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int LATENCY    = 1285,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_frame_start,
  input  logic [11:0]       i_pix_in,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [11:0]       o_mem_data,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overflow
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW = $clog2(LATENCY + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 2);
  localparam logic [PW:0]       CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [11:0]       data;
  } entry_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LW-1:0]     r_fill_cnt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_addr;

  entry_t [FIFO_DEPTH-1:0] r_mem;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW:0]             r_count;
  logic                    r_overflow;

  logic   w_start;
  logic   w_push;
  logic   w_last;
  logic   w_full;
  logic   w_pop;
  logic   w_wr;
  logic   w_drop;
  logic   w_border;
  entry_t w_entry;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  assign w_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // The fill counter reaches 0 exactly in the cycle the first centre pixel is
  // on i_pix_in, so that cycle already pushes; STREAM covers the remainder.
  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_push       = 1'b0;
    o_busy       = 1'b0;
    o_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_frame_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        o_busy = 1'b1;
        if (r_fill_cnt == '0) begin
          w_push      = 1'b1;
          w_state_nxt = w_last ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        o_busy = 1'b1;
        w_push = 1'b1;
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (r_count == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fill counter and raster position
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fill_cnt <= '0;
    end else if (w_start) begin
      r_fill_cnt <= LW'(LATENCY - 1);
    end else if (r_state == S_FILL && r_fill_cnt != '0) begin
      r_fill_cnt <= r_fill_cnt - LW'(1);
    end
  end

  // Centre pixels start on line 1: line 0 and line IMG_H-1 never sit in the
  // middle of the window. addr is a running counter, no multiply.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (w_start) begin
      r_col  <= '0;
      r_row  <= RW'(1);
      r_addr <= ADDR_W'(IMG_W);
    end else if (w_push) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign w_border = (r_col == '0) || (r_col == COL_LAST);

`ifdef BORDER_ZERO_EN
  // At the border columns the window spans two lines; write black instead.
  assign w_entry.data = w_border ? 12'h000 : i_pix_in;
`else
  assign w_entry.data = i_pix_in;
`endif
  assign w_entry.addr = r_addr;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = (r_count != '0) && i_mem_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  r_overflow <= 1'b0;
    else if (w_start) r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
  end

  assign o_mem_we   = (r_count != '0);
  assign o_mem_addr = r_mem[r_rd_ptr].addr;
  assign o_mem_data = r_mem[r_rd_ptr].data;
  assign o_overflow = r_overflow;

  logic w_unused;
  assign w_unused = w_border;

endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer with a small 8x4 image.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge by a monitor that only records, the main sequence checks.
module tb_conv_frame_writer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int L  = 19;
  localparam int D  = 4;
  localparam int AW = 19;
  localparam int N  = (H - 2) * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          mem_ready = 1'b1;
  logic [11:0]   pix_in;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_data;
  logic          mem_we;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  assign pix_in = cyc[11:0];

  conv_frame_writer #(
    .IMG_W(W), .IMG_H(H), .LATENCY(L), .FIFO_DEPTH(D), .ADDR_W(AW)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_frame_start(frame_start),
    .i_pix_in     (pix_in),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_mem_we     (mem_we),
    .i_mem_ready  (mem_ready),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_overflow   (overflow)
  );

  // ---------------------------------------------------------------- monitor
  int            cap_addr[$];
  int            cap_data[$];
  int            we_rise[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            busy_err = 0;
  int            hold_err = 0;
  logic          prev_we = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [11:0]   prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_we    = 1'b0;
    end else begin
      if (mem_we && mem_ready) begin
        cap_addr.push_back(int'(mem_addr));
        cap_data.push_back(int'(mem_data));
      end
      if (mem_we && !prev_we) we_rise.push_back(cyc);
      if (frame_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
        if (busy) busy_err = busy_err + 1;
      end
      if (prev_stall && (mem_addr != prev_addr || mem_data != prev_data))
        hold_err = hold_err + 1;
      prev_stall = mem_we && !mem_ready;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end
  end

  // ---------------------------------------------------------------- helpers
  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 2000) begin
      step();
      g++;
    end
  endtask

  function automatic int exp_data(input int t, input int k);
`ifdef BORDER_ZERO_EN
    if ((k % W) == 0 || (k % W) == W - 1) return 0;
`endif
    return (t + L + k) & 12'hFFF;
  endfunction

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " mem_we"},     int'(mem_we),     0);
    chk({nm, " mem_addr"},   int'(mem_addr),   0);
    chk({nm, " mem_data"},   int'(mem_data),   0);
    chk({nm, " busy"},       int'(busy),       0);
    chk({nm, " frame_done"}, int'(frame_done), 0);
    chk({nm, " overflow"},   int'(overflow),   0);
  endtask

  // One full frame: frame_start at cycle t, mem_ready low for lo_len cycles
  // from the first push, optional extra frame_start at first push + roff.
  // Entries k in [drop_lo, drop_hi] are expected to be dropped.
  task automatic run_frame(input string nm, input int t, input int lo_len,
                           input int roff, input int exp_w, input int drop_lo,
                           input int drop_hi, input bit exp_ovf);
    int b_cap, b_rise, b_done, b_busy, b_hold, p, g, idx;
    b_cap  = cap_addr.size();
    b_rise = we_rise.size();
    b_done = done_cnt;
    b_busy = busy_err;
    b_hold = hold_err;
    goto_cyc(t);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk({nm, " ovf_clear_on_start"}, int'(overflow), 0);
    chk({nm, " busy_in_fill"},       int'(busy),     1);
    p = t + L;
    g = 0;
    while (done_cnt == b_done && g < 400) begin
      mem_ready   = !(cyc >= p && cyc < p + lo_len);
      frame_start = (roff > 0 && cyc == p + roff);
      step();
      g++;
    end
    mem_ready   = 1'b1;
    frame_start = 1'b0;
    repeat (4) step();

    chk({nm, " write_count"}, cap_addr.size() - b_cap, exp_w);
    idx = b_cap;
    for (int k = 0; k < N; k++) begin
      if (k >= drop_lo && k <= drop_hi) continue;
      if (idx < cap_addr.size()) begin
        chk($sformatf("%s addr[%0d]", nm, k), cap_addr[idx], W + k);
        chk($sformatf("%s data[%0d]", nm, k), cap_data[idx], exp_data(t, k));
      end
      idx++;
    end
    chk({nm, " overflow"},   int'(overflow), int'(exp_ovf));
    chk({nm, " done_count"}, done_cnt - b_done, 1);
    chk({nm, " done_after_last_push+3"}, int'(done_cyc >= p + N - 1 + 3), 1);
    chk({nm, " busy_with_done"}, busy_err - b_busy, 0);
    chk({nm, " head_hold"},      hold_err - b_hold, 0);
    if (we_rise.size() > b_rise)
      chk({nm, " first_we_cycle"}, we_rise[b_rise], p + 1);
    else
      chk({nm, " first_we_cycle"}, -1, p + 1);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    string nm;
    int    lo_len;
    int    roff;
    int    exp_w;
    int    drop_lo;
    int    drop_hi;
    bit    exp_ovf;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int t;
    int tr;

    tbl[0] = '{"basic",    0, 0, 16, -1, -1, 1'b0};
    tbl[1] = '{"stall",    6, 0, 14,  4,  5, 1'b1};
    tbl[2] = '{"fullpop",  4, 0, 16, -1, -1, 1'b0};
    tbl[3] = '{"restart",  0, 5, 16, -1, -1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      t = (i == 0) ? 10 : cyc + 4;
      run_frame(tbl[i].nm, t, tbl[i].lo_len, tbl[i].roff, tbl[i].exp_w,
                tbl[i].drop_lo, tbl[i].drop_hi, tbl[i].exp_ovf);
      if (i == 0) begin
        // Hand-computed anchors for the first frame started at cycle 10.
        chk("basic first_addr", cap_addr.size() > 0 ? cap_addr[0] : -1, 8);
`ifdef BORDER_ZERO_EN
        chk("basic first_data", cap_data.size() > 0 ? cap_data[0] : -1, 0);
        chk("basic addr9_data", cap_data.size() > 1 ? cap_data[1] : -1, 30);
`else
        chk("basic first_data", cap_data.size() > 0 ? cap_data[0] : -1, 29);
`endif
        chk("basic first_we_30", we_rise.size() > 0 ? we_rise[0] : -1, 30);
      end
    end

    // Reset in the middle of STREAM after 5 pushes.
    tr = cyc + 4;
    goto_cyc(tr);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    goto_cyc(tr + L + 5);
    chk("midreset busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    chk("midreset fifo_empty", int'(mem_we), 0);
    rst_n = 1'b1;

    run_frame("after_reset", 10, 0, 0, 16, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
